// File: rtl/i2s_dac_if.sv
// Sample-source / codec-side bundle for the I2S DAC transmitter.
// master: the transmitter; slave: whoever supplies samples and watches the serial lines.
interface i2s_dac_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] audio_output_left;
    logic [DATA_WIDTH-1:0] audio_output_right;
    logic                  mute;
    logic                  sample_end;
    logic                  aud_bclk;
    logic                  aud_daclrck;
    logic                  aud_dacdat;

    modport master (
        input  audio_output_left,
        input  audio_output_right,
        input  mute,
        output sample_end,
        output aud_bclk,
        output aud_daclrck,
        output aud_dacdat
    );

    modport slave (
        output audio_output_left,
        output audio_output_right,
        output mute,
        input  sample_end,
        input  aud_bclk,
        input  aud_daclrck,
        input  aud_dacdat
    );
endinterface

// File: rtl/i2s_dac_tx.sv
// I2S DAC transmitter: divides clk into bclk/lrclk and shifts out one left and one
// right sample per frame, MSB first with the one-bit I2S delay after each lrclk edge.
module i2s_dac_tx #(
    parameter int unsigned BCLK_HALF  = 4,
    parameter int unsigned SLOT_BITS  = 32,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic      clk,
    input  logic      reset_n,
    i2s_dac_if.master dac_io
);
    localparam int unsigned DivW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam int unsigned BitW = $clog2(2 * SLOT_BITS);
    localparam int unsigned IdxW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [DivW-1:0] DivLast = DivW'(BCLK_HALF - 1);
    localparam logic [BitW-1:0] BitLast = BitW'(2 * SLOT_BITS - 1);
    localparam logic [BitW-1:0] SlotLen = BitW'(SLOT_BITS);
    localparam logic [BitW-1:0] DataLen = BitW'(DATA_WIDTH);

    logic [DivW-1:0]       div_cnt_q;
    logic                  bclk_q;
    logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                  lrck_q, lrck_d;
    logic                  dat_q, dat_d;
    logic                  sample_end_q;
    logic [DATA_WIDTH-1:0] left_q, right_q;

    logic                  div_wrap, fall, boundary;
    logic [BitW-1:0]       pos;
    logic [IdxW-1:0]       idx;
    logic [DATA_WIDTH-1:0] shadow;

    always_comb begin
        div_wrap  = (div_cnt_q == DivLast);
        fall      = div_wrap & bclk_q;
        bit_cnt_d = (bit_cnt_q == BitLast) ? '0 : bit_cnt_q + BitW'(1);
        boundary  = fall & (bit_cnt_d == '0);
        lrck_d    = (bit_cnt_d >= SlotLen);
        pos       = lrck_d ? (bit_cnt_d - SlotLen) : bit_cnt_d;
        shadow    = lrck_d ? right_q : left_q;
        idx       = IdxW'(DataLen - pos);
        // Position 0 is the I2S delay slot; positions past the LSB pad with zeros.
        dat_d     = ((pos != '0) && (pos <= DataLen)) ? shadow[idx] : 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_q    <= '0;
            bclk_q       <= 1'b0;
            bit_cnt_q    <= BitLast;
            lrck_q       <= 1'b1;
            dat_q        <= 1'b0;
            sample_end_q <= 1'b0;
            left_q       <= '0;
            right_q      <= '0;
        end else begin
            if (div_wrap) begin
                div_cnt_q <= '0;
                bclk_q    <= ~bclk_q;
            end else begin
                div_cnt_q <= div_cnt_q + DivW'(1);
            end

            sample_end_q <= boundary;

            if (fall) begin
                bit_cnt_q <= bit_cnt_d;
                lrck_q    <= lrck_d;
                dat_q     <= dat_d;
            end

            // Shadows load on the delay bit, so the new sample is first used one bclk later.
            if (boundary) begin
                left_q  <= dac_io.mute ? '0 : dac_io.audio_output_left;
                right_q <= dac_io.mute ? '0 : dac_io.audio_output_right;
            end
        end
    end

    assign dac_io.sample_end  = sample_end_q;
    assign dac_io.aud_bclk    = bclk_q;
    assign dac_io.aud_daclrck = lrck_q;
    assign dac_io.aud_dacdat  = dat_q;
endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed bench for i2s_dac_tx: reset, frame timing, bit order, handshake, mute and a
// short-slot parameter variant, with frames decoded from the serial lines.
module tb_i2s_dac_tx;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    i2s_dac_if #(.DATA_WIDTH(16)) if1 ();
    i2s_dac_if #(.DATA_WIDTH(16)) if2 ();

    i2s_dac_tx #(.BCLK_HALF(4), .SLOT_BITS(32), .DATA_WIDTH(16)) u_dut (
        .clk    (clk),
        .reset_n(reset_n),
        .dac_io (if1)
    );

    i2s_dac_tx #(.BCLK_HALF(2), .SLOT_BITS(17), .DATA_WIDTH(16)) u_dut2 (
        .clk    (clk),
        .reset_n(reset_n),
        .dac_io (if2)
    );

    typedef struct {
        logic [15:0] left;
        logic [15:0] right;
        logic        mute;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic bclk_of(input bit sel);
        return sel ? if2.aud_bclk : if1.aud_bclk;
    endfunction
    function automatic logic lrck_of(input bit sel);
        return sel ? if2.aud_daclrck : if1.aud_daclrck;
    endfunction
    function automatic logic dat_of(input bit sel);
        return sel ? if2.aud_dacdat : if1.aud_dacdat;
    endfunction
    function automatic logic se_of(input bit sel);
        return sel ? if2.sample_end : if1.sample_end;
    endfunction

    // Returns the number of clk edges until sample_end is seen (0 on timeout).
    task automatic wait_se(input bit sel, output int cycles);
        cycles = 0;
        for (int c = 1; c <= 2000; c++) begin
            @(posedge clk);
            #1;
            if (se_of(sel)) begin
                cycles = c;
                break;
            end
        end
        if (cycles == 0) chk("sample_end_timeout", 32'd0, 32'd1);
    endtask

    // Decodes one frame starting right after a boundary, sampling on bclk rising edges.
    task automatic capture(input bit sel, input int slot, output logic [15:0] l,
                           output logic [15:0] r, output int lr_bad, output int pad_bad,
                           output int nbits);
        logic prev, cur, d;
        int   p;
        bit   ch;
        l = '0; r = '0; lr_bad = 0; pad_bad = 0; nbits = 0;
        prev = bclk_of(sel);
        for (int c = 0; c < 2000 && nbits < 2 * slot; c++) begin
            @(posedge clk);
            #1;
            cur = bclk_of(sel);
            if (cur && !prev) begin
                ch = (nbits >= slot);
                p  = nbits % slot;
                d  = dat_of(sel);
                if (lrck_of(sel) !== ch) lr_bad++;
                if (p >= 1 && p <= 16) begin
                    if (ch) r = {r[14:0], d};
                    else    l = {l[14:0], d};
                end else if (d !== 1'b0) begin
                    pad_bad++;
                end
                nbits++;
            end
            prev = cur;
        end
    endtask

    initial begin
        int          cyc, lr_bad, pad_bad, nbits;
        logic [15:0] l, r;
        int          first_se, last_se, se_cnt, se_bad;
        int          last_lr, lr_tog, lrt_bad, last_b, b_bad;
        logic        se, prev_se, prev_lr, prev_b;

        vecs[0] = '{16'h8001, 16'h7FFE, 1'b0, 16'h8001, 16'h7FFE};
        vecs[1] = '{16'h1234, 16'hABCD, 1'b0, 16'h1234, 16'hABCD};
        vecs[2] = '{16'h1234, 16'hABCD, 1'b1, 16'h0000, 16'h0000};
        vecs[3] = '{16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 16'h0000};
        vecs[4] = '{16'h0000, 16'hFFFF, 1'b1, 16'h0000, 16'h0000};
        vecs[5] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'hA5A5, 16'h5A5A};

        if1.audio_output_left  = 16'hDEAD;
        if1.audio_output_right = 16'hBEEF;
        if1.mute               = 1'b0;
        if2.audio_output_left  = 16'h0000;
        if2.audio_output_right = 16'h0000;
        if2.mute               = 1'b0;

        // Reset state with clocks running
        repeat (5) @(posedge clk);
        #1;
        chk("rst_bclk", 32'(if1.aud_bclk), 32'd0);
        chk("rst_lrck", 32'(if1.aud_daclrck), 32'd1);
        chk("rst_dat", 32'(if1.aud_dacdat), 32'd0);
        chk("rst_se", 32'(if1.sample_end), 32'd0);

        // Frame timing
        @(negedge clk);
        reset_n = 1'b1;
        first_se = -1; last_se = -1; se_cnt = 0; se_bad = 0;
        last_lr = -1; lr_tog = 0; lrt_bad = 0; last_b = -1; b_bad = 0;
        prev_se = 1'b0; prev_lr = 1'b1; prev_b = 1'b0;
        for (int c = 1; c <= 5000; c++) begin
            @(posedge clk);
            #1;
            se = if1.sample_end;
            if (se) begin
                if (first_se < 0) first_se = c;
                else if (c - last_se != 512) se_bad++;
                if (prev_se) se_bad++;
                se_cnt++;
                last_se = c;
            end
            prev_se = se;
            if (if1.aud_daclrck !== prev_lr) begin
                if (last_lr >= 0 && c - last_lr != 256) lrt_bad++;
                last_lr = c;
                lr_tog++;
            end
            prev_lr = if1.aud_daclrck;
            if (if1.aud_bclk && !prev_b) begin
                if (last_b >= 0 && c - last_b != 8) b_bad++;
                last_b = c;
            end
            prev_b = if1.aud_bclk;
        end
        chk("first_se_edge", 32'(first_se), 32'd8);
        chk("se_count", 32'(se_cnt), 32'd10);
        chk("se_spacing_width", 32'(se_bad), 32'd0);
        chk("lrck_toggles", 32'(lr_tog), 32'd20);
        chk("lrck_half_period", 32'(lrt_bad), 32'd0);
        chk("bclk_period", 32'(b_bad), 32'd0);

        // Table-driven frames: set inputs after a boundary, decode the frame after the next one
        foreach (vecs[i]) begin
            wait_se(1'b0, cyc);
            if1.audio_output_left  = vecs[i].left;
            if1.audio_output_right = vecs[i].right;
            if1.mute               = vecs[i].mute;
            wait_se(1'b0, cyc);
            capture(1'b0, 32, l, r, lr_bad, pad_bad, nbits);
            chk($sformatf("vec%0d_left", i), 32'(l), 32'(vecs[i].exp_l));
            chk($sformatf("vec%0d_right", i), 32'(r), 32'(vecs[i].exp_r));
            chk($sformatf("vec%0d_lrck", i), 32'(lr_bad), 32'd0);
            chk($sformatf("vec%0d_pad", i), 32'(pad_bad + (64 - nbits)), 32'd0);
        end

        // Mute raised mid-frame leaves the frame in flight intact
        if1.audio_output_left  = 16'h1234;
        if1.audio_output_right = 16'hABCD;
        if1.mute               = 1'b0;
        wait_se(1'b0, cyc);
        wait_se(1'b0, cyc);
        fork
            capture(1'b0, 32, l, r, lr_bad, pad_bad, nbits);
            begin
                repeat (200) @(posedge clk);
                if1.mute = 1'b1;
            end
        join
        chk("mute_inflight_left", 32'(l), 32'h1234);
        chk("mute_inflight_right", 32'(r), 32'hABCD);
        wait_se(1'b0, cyc);
        if1.mute = 1'b0;
        capture(1'b0, 32, l, r, lr_bad, pad_bad, nbits);
        chk("muted_frame", 32'({l, r}), 32'h0);
        wait_se(1'b0, cyc);
        capture(1'b0, 32, l, r, lr_bad, pad_bad, nbits);
        chk("unmuted_frame", 32'({l, r}), 32'h1234ABCD);

        // Handshake: counter advanced on each sample_end, each frame carries the previous value
        wait_se(1'b0, cyc);
        if1.audio_output_left  = 16'd0;
        if1.audio_output_right = 16'd0;
        capture(1'b0, 32, l, r, lr_bad, pad_bad, nbits);
        for (int i = 1; i <= 20; i++) begin
            wait_se(1'b0, cyc);
            chk($sformatf("hs%0d_period", i), 32'(cyc), 32'd4);
            if1.audio_output_left  = 16'(i);
            if1.audio_output_right = 16'(i);
            capture(1'b0, 32, l, r, lr_bad, pad_bad, nbits);
            chk($sformatf("hs%0d_frame", i), 32'({l, r}), {16'(i - 1), 16'(i - 1)});
        end

        // Asynchronous reset in the middle of the left slot
        wait_se(1'b0, cyc);
        repeat (100) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_rst_bclk", 32'(if1.aud_bclk), 32'd0);
        chk("async_rst_lrck", 32'(if1.aud_daclrck), 32'd1);
        chk("async_rst_dat", 32'(if1.aud_dacdat), 32'd0);
        chk("async_rst_se", 32'(if1.sample_end), 32'd0);

        // Short-slot variant: LSB at slot position 16, no padding
        @(negedge clk);
        reset_n = 1'b1;
        wait_se(1'b1, cyc);
        chk("v2_first_se", 32'(cyc), 32'd4);
        if2.audio_output_left  = 16'h8001;
        if2.audio_output_right = 16'hC003;
        wait_se(1'b1, cyc);
        chk("v2_frame_period", 32'(cyc), 32'd136);
        capture(1'b1, 17, l, r, lr_bad, pad_bad, nbits);
        chk("v2_left", 32'(l), 32'h8001);
        chk("v2_right", 32'(r), 32'hC003);
        chk("v2_lrck", 32'(lr_bad), 32'd0);
        chk("v2_bits", 32'(nbits), 32'd34);
        chk("v2_delay_bit", 32'(pad_bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/i2s_dac_tx.md
Name: i2s_dac_tx

Overview:
Downstream consumer of the sample sources (tone ROM, effects chain). Generates the codec bit clock and LR clock and serialises one left and one right 16-bit sample per frame onto the codec DAC data line in I2S format. Emits a one-cycle `sample_end` strobe at each frame boundary. Sources advance to their next sample on that strobe.

Parameters:
BCLK_HALF, 4, clk cycles per half period of aud_bclk (must be >= 2)
SLOT_BITS, 32, bclk periods per channel slot (must be >= DATA_WIDTH+1)
DATA_WIDTH, 16, sample width in bits, two's complement

Ports:
clk  input  1  system clock (24.576 MHz nominal; defaults give 48 kHz frames)
reset_n  input  1  asynchronous active-low reset
audio_output_left  input  DATA_WIDTH  left sample from the upstream source
audio_output_right  input  DATA_WIDTH  right sample from the upstream source
mute  input  1  when high, zeros are latched instead of the inputs
sample_end  output  1  one-clk strobe; inputs were latched this frame boundary
aud_bclk  output  1  codec bit clock
aud_daclrck  output  1  codec LR clock: 0 = left slot, 1 = right slot
aud_dacdat  output  1  serial DAC data

Behaviour:
- Reset values (asserted asynchronously, effective immediately, also mid-frame):
  - div_cnt = 0, aud_bclk = 0, bit_cnt = 2*SLOT_BITS-1, aud_daclrck = 1, aud_dacdat = 0, sample_end = 0.
  - Left and right shadow registers = 0.
- Divider:
  - div_cnt counts 0..BCLK_HALF-1 and wraps.
  - On each wrap, aud_bclk toggles.
- Fall event: the clk edge where div_cnt == BCLK_HALF-1 and aud_bclk == 1. All serial outputs change only on a fall event, so the codec samples on the bclk rising edge.
- On a fall event:
  - bit_cnt increments, wrapping from 2*SLOT_BITS-1 to 0.
  - aud_daclrck <= (new bit_cnt >= SLOT_BITS).
  - Slot position p = new bit_cnt mod SLOT_BITS. The slot's shadow is left when new bit_cnt < SLOT_BITS, otherwise right.
  - aud_dacdat value by position:
    - p == 0: 0 (I2S one-bit delay).
    - 1 <= p <= DATA_WIDTH: bit (DATA_WIDTH-p) of the slot's shadow, MSB first.
    - p > DATA_WIDTH: 0.
- Frame boundary: a fall event where bit_cnt wraps to 0.
  - Same edge: shadows <= mute ? 0 : inputs.
  - sample_end is registered high for exactly one clk cycle following that edge; it is low at all other times.
- Source handshake:
  - The source may update its inputs any time after sample_end.
  - The new value is latched at the next boundary, one full frame (2*SLOT_BITS*2*BCLK_HALF clks) later.
  - Every boundary latches exactly once, so no sample is skipped or duplicated.
- First boundary after reset release occurs 2*BCLK_HALF clks after release (bclk rises at cycle BCLK_HALF, falls at 2*BCLK_HALF). The first frame transmits the inputs present at that edge.
- Frame period = 4*SLOT_BITS*BCLK_HALF clks (512 with defaults). aud_daclrck duty is exactly 50%.
- mute is sampled only at frame boundaries. A change mid-frame does not corrupt the frame in flight.
- No combinational path from any input to any output.

Test Plan:
1. Reset state: hold reset_n=0 with arbitrary inputs.
   -> aud_bclk=0, aud_daclrck=1, aud_dacdat=0, sample_end=0.
   - Assert reset_n=0 mid-frame -> the same values appear immediately, without a clk edge.
2. Frame timing: release reset, run 5000 clks.
   -> First sample_end high in the cycle after clk edge 8.
   -> Subsequent pulses exactly 512 clks apart, each one cycle wide.
   -> aud_daclrck toggles every 256 clks.
   -> aud_bclk period is 8 clks.
3. Bit order: left=16'h8001, right=16'h7FFE. Capture aud_dacdat on aud_bclk rising edges for one full frame.
   -> Left slot: 0,1,0x14,1,0x15 (i.e. delay 0, then 1000...0001, then zeros).
   -> Right slot: 0,0,1x14,0,0x15.
   -> aud_daclrck is 0 for the left 32 bits and 1 for the right 32 bits.
4. Handshake: drive left=right from a 16-bit counter that increments on sample_end, starting at 0.
   -> Decoded frames carry 0,1,2,3,... consecutively for 20 frames, with no skip or repeat.
5. Mute: left=16'h1234, right=16'hABCD.
   - Raise mute mid-frame -> the current frame still carries 1234/ABCD.
   - The next frame is all zeros.
   - Drop mute -> the following frame carries 1234/ABCD again.
6. Parameter variant: BCLK_HALF=2, SLOT_BITS=17.
   -> Frame period 136 clks.
   -> LSB occupies slot position 16.
   -> No zero padding after the LSB.
